// File: rtl/std_gray_counter_pkg.sv
// ----------------------------------------------------------------------------
// std_gray_counter_pkg
//
// Purpose : Small set of types shared by the Gray counter slice. The only
//           item today is the decoded count-step request, which keeps the
//           next-state logic in the top readable.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package std_gray_counter_pkg;

    // Decoded request for the current edge once clear/set have been ruled out.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

endpackage : std_gray_counter_pkg

// File: rtl/std_gray_decoder.sv
// ----------------------------------------------------------------------------
// std_gray_decoder
//
// Purpose : Purely combinational Gray-to-binary converter.
// Ports   : gray - Gray-coded input, WIDTH bits
//           bin  - binary output, WIDTH bits
// ----------------------------------------------------------------------------
module std_gray_decoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it. Written as a
    // reduction of a shifted copy so no bit depends on another output bit.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule : std_gray_decoder

// File: rtl/std_gray_encoder.sv
// ----------------------------------------------------------------------------
// std_gray_encoder
//
// Purpose : Purely combinational binary-to-Gray converter.
// Ports   : bin  - binary input, WIDTH bits
//           gray - Gray-coded output, WIDTH bits
// ----------------------------------------------------------------------------
module std_gray_encoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule : std_gray_encoder

// File: rtl/std_gray_counter.sv
// ----------------------------------------------------------------------------
// std_gray_counter
//
// Purpose : Up/down binary counter with a registered, glitch-free Gray copy of
//           the count, synchronous clear/load, wrap or saturate behaviour and
//           boundary flags. The Gray register is loaded from an encode of the
//           next binary value so it changes cleanly on the clock edge.
//
// Parameters:
//   WIDTH         counter width, 1..32
//   INITIAL_VALUE binary value used by reset and clear
//   WRAP          1 = modulo wrap, 0 = saturate at 0 and max
//   SET_GRAY      1 = i_set_value is Gray-coded, 0 = binary
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_clear      synchronous return to INITIAL_VALUE (highest priority)
//   i_set        synchronous load of i_set_value
//   i_set_value  load value, encoding selected by SET_GRAY
//   i_up         increment request
//   i_down       decrement request
//   o_count      registered binary count
//   o_gray       registered Gray code of o_count
//   o_at_max     o_count is all ones
//   o_at_min     o_count is zero
//   o_wrap       one-cycle pulse after a count step crossed the boundary
// ----------------------------------------------------------------------------
module std_gray_counter
    import std_gray_counter_pkg::*;
#(
    parameter int          WIDTH         = 8,
    parameter int unsigned INITIAL_VALUE = 0,
    parameter bit          WRAP          = 1'b1,
    parameter bit          SET_GRAY      = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_set,
    input  logic [WIDTH-1:0] i_set_value,
    input  logic             i_up,
    input  logic             i_down,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_gray,
    output logic             o_at_max,
    output logic             o_at_min,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INITIAL_VALUE);
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] set_bin;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;
    step_e            step;

    // Load path: a Gray-coded load value is decoded once here so the counter
    // itself only ever holds binary.
    generate
        if (SET_GRAY) begin : g_set_gray
            std_gray_decoder #(
                .WIDTH (WIDTH)
            ) u_set_decoder (
                .gray (i_set_value),
                .bin  (set_bin)
            );
        end else begin : g_set_bin
            assign set_bin = i_set_value;
        end
    endgenerate

    // Opposing or absent requests both mean hold.
    always_comb begin
        step = STEP_HOLD;
        if (i_up && !i_down) begin
            step = STEP_UP;
        end else if (i_down && !i_up) begin
            step = STEP_DOWN;
        end
    end

    // Next binary value and wrap pulse. Only a count step can raise the wrap
    // pulse; clear and set may jump across the boundary without flagging it.
    always_comb begin
        next_count = o_count;
        next_wrap  = 1'b0;
        if (i_clear) begin
            next_count = INIT_BIN;
        end else if (i_set) begin
            next_count = set_bin;
        end else begin
            case (step)
                STEP_UP: begin
                    if (o_count == MAX_VAL) begin
                        if (WRAP) begin
                            next_count = MIN_VAL;
                            next_wrap  = 1'b1;
                        end
                    end else begin
                        next_count = o_count + ONE;
                    end
                end
                STEP_DOWN: begin
                    if (o_count == MIN_VAL) begin
                        if (WRAP) begin
                            next_count = MAX_VAL;
                            next_wrap  = 1'b1;
                        end
                    end else begin
                        next_count = o_count - ONE;
                    end
                end
                default: begin
                    next_count = o_count;
                end
            endcase
        end
    end

    // Gray value is computed from the next binary value so that the register
    // below holds it directly; o_gray never passes through combinational logic.
    std_gray_encoder #(
        .WIDTH (WIDTH)
    ) u_next_encoder (
        .bin  (next_count),
        .gray (next_gray)
    );

    // All state lives here: binary count, its Gray twin and the wrap pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= INIT_BIN;
            o_gray  <= INIT_GRAY;
            o_wrap  <= 1'b0;
        end else begin
            o_count <= next_count;
            o_gray  <= next_gray;
            o_wrap  <= next_wrap;
        end
    end

    // Boundary flags decode the binary register only.
    assign o_at_max = (o_count == MAX_VAL);
    assign o_at_min = (o_count == MIN_VAL);

endmodule : std_gray_counter

// File: tb/tb_std_gray_counter.sv
// ----------------------------------------------------------------------------
// tb_std_gray_counter
//
// Purpose : Directed self-checking bench for std_gray_counter. Four instances
//           cover the wrapping 4-bit counter with a non-zero initial value,
//           a saturating 4-bit counter, an 8-bit counter with Gray-coded load
//           and a 1-bit counter.
// Ports   : none (top-level bench)
// ----------------------------------------------------------------------------
module tb_std_gray_counter;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    // Instance A: WIDTH 4, INITIAL_VALUE 5, wrapping, binary load
    logic       a_clear, a_set, a_up, a_down;
    logic [3:0] a_set_value;
    logic [3:0] a_count, a_gray;
    logic       a_at_max, a_at_min, a_wrap;

    // Instance B: WIDTH 4, INITIAL_VALUE 0, saturating, binary load
    logic       b_clear, b_set, b_up, b_down;
    logic [3:0] b_set_value;
    logic [3:0] b_count, b_gray;
    logic       b_at_max, b_at_min, b_wrap;

    // Instance C: WIDTH 8, INITIAL_VALUE 0, wrapping, Gray-coded load
    logic       c_clear, c_set, c_up, c_down;
    logic [7:0] c_set_value;
    logic [7:0] c_count, c_gray;
    logic       c_at_max, c_at_min, c_wrap;

    // Instance D: WIDTH 1, INITIAL_VALUE 0, wrapping
    logic       d_clear, d_set, d_up, d_down;
    logic [0:0] d_set_value;
    logic [0:0] d_count, d_gray;
    logic       d_at_max, d_at_min, d_wrap;

    std_gray_counter #(
        .WIDTH(4), .INITIAL_VALUE(5), .WRAP(1'b1), .SET_GRAY(1'b0)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(a_clear), .i_set(a_set),
        .i_set_value(a_set_value), .i_up(a_up), .i_down(a_down),
        .o_count(a_count), .o_gray(a_gray), .o_at_max(a_at_max),
        .o_at_min(a_at_min), .o_wrap(a_wrap)
    );

    std_gray_counter #(
        .WIDTH(4), .INITIAL_VALUE(0), .WRAP(1'b0), .SET_GRAY(1'b0)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(b_clear), .i_set(b_set),
        .i_set_value(b_set_value), .i_up(b_up), .i_down(b_down),
        .o_count(b_count), .o_gray(b_gray), .o_at_max(b_at_max),
        .o_at_min(b_at_min), .o_wrap(b_wrap)
    );

    std_gray_counter #(
        .WIDTH(8), .INITIAL_VALUE(0), .WRAP(1'b1), .SET_GRAY(1'b1)
    ) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(c_clear), .i_set(c_set),
        .i_set_value(c_set_value), .i_up(c_up), .i_down(c_down),
        .o_count(c_count), .o_gray(c_gray), .o_at_max(c_at_max),
        .o_at_min(c_at_min), .o_wrap(c_wrap)
    );

    std_gray_counter #(
        .WIDTH(1), .INITIAL_VALUE(0), .WRAP(1'b1), .SET_GRAY(1'b0)
    ) dut_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(d_clear), .i_set(d_set),
        .i_set_value(d_set_value), .i_up(d_up), .i_down(d_down),
        .o_count(d_count), .o_gray(d_gray), .o_at_max(d_at_max),
        .o_at_min(d_at_min), .o_wrap(d_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the next rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_clear = 0; a_set = 0; a_set_value = '0; a_up = 0; a_down = 0;
        b_clear = 0; b_set = 0; b_set_value = '0; b_up = 0; b_down = 0;
        c_clear = 0; c_set = 0; c_set_value = '0; c_up = 0; c_down = 0;
        d_clear = 0; d_set = 0; d_set_value = '0; d_up = 0; d_down = 0;
        #12;
        vectors++;
        if (a_count !== 4'd5) begin
            miscompares++;
            $display("[TB] FAIL reset_count got %0d want 5", a_count);
        end
        vectors++;
        if (a_gray !== 4'b0111) begin
            miscompares++;
            $display("[TB] FAIL reset_gray got %b want 0111", a_gray);
        end
        vectors++;
        if (a_wrap !== 1'b0 || a_at_max !== 1'b0 || a_at_min !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got wrap=%b max=%b min=%b want 0 0 0",
                     a_wrap, a_at_max, a_at_min);
        end
        vectors++;
        if (b_count !== 4'd0 || b_at_min !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_b got count=%0d min=%b want 0 1", b_count, b_at_min);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_count();
        logic [3:0] exp;
        logic [3:0] prev_gray;
        // Park the counter at 0 first.
        a_set = 1; a_set_value = 4'd0;
        tick();
        a_set = 0; a_up = 1;
        vectors++;
        if (a_count !== 4'd0 || a_gray !== 4'd0 || a_at_min !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_start got count=%0d gray=%b min=%b want 0 0000 1",
                     a_count, a_gray, a_at_min);
        end
        for (int i = 1; i <= 16; i++) begin
            prev_gray = a_gray;
            tick();
            exp = 4'(i);
            vectors++;
            if (a_count !== exp) begin
                miscompares++;
                $display("[TB] FAIL wrap_count step %0d got %0d want %0d", i, a_count, exp);
            end
            vectors++;
            if (a_gray !== (exp ^ (exp >> 1))) begin
                miscompares++;
                $display("[TB] FAIL wrap_gray step %0d got %b want %b", i, a_gray, exp ^ (exp >> 1));
            end
            vectors++;
            if ($countones(a_gray ^ prev_gray) != 1) begin
                miscompares++;
                $display("[TB] FAIL gray_one_bit step %0d got %0d bits changed want 1",
                         i, $countones(a_gray ^ prev_gray));
            end
            vectors++;
            if (a_wrap !== (i == 16)) begin
                miscompares++;
                $display("[TB] FAIL wrap_pulse step %0d got %b want %b", i, a_wrap, (i == 16));
            end
            vectors++;
            if (a_at_max !== (exp == 4'd15)) begin
                miscompares++;
                $display("[TB] FAIL at_max step %0d got %b want %b", i, a_at_max, (exp == 4'd15));
            end
        end
        a_up = 0;
        tick();
        vectors++;
        if (a_wrap !== 1'b0 || a_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_pulse_end got wrap=%b count=%0d want 0 0", a_wrap, a_count);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_seq [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        b_set = 1; b_set_value = 4'd2;
        tick();
        b_set = 0; b_down = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (b_count !== exp_seq[i] || b_wrap !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL sat_down step %0d got count=%0d wrap=%b want %0d 0",
                         i, b_count, b_wrap, exp_seq[i]);
            end
            vectors++;
            if (b_at_min !== (exp_seq[i] == 4'd0)) begin
                miscompares++;
                $display("[TB] FAIL sat_at_min step %0d got %b want %b",
                         i, b_at_min, (exp_seq[i] == 4'd0));
            end
        end
        b_down = 0;
        b_set = 1; b_set_value = 4'd14;
        tick();
        b_set = 0; b_up = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (b_count !== 4'd15 || b_gray !== 4'b1000 || b_at_max !== 1'b1 || b_wrap !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL sat_up step %0d got count=%0d gray=%b max=%b wrap=%b want 15 1000 1 0",
                         i, b_count, b_gray, b_at_max, b_wrap);
            end
        end
        b_up = 0;
    endtask

    task automatic test_priority();
        a_clear = 1; a_set = 1; a_set_value = 4'd9; a_up = 1;
        tick();
        vectors++;
        if (a_count !== 4'd5 || a_gray !== 4'b0111) begin
            miscompares++;
            $display("[TB] FAIL prio_clear got count=%0d gray=%b want 5 0111", a_count, a_gray);
        end
        a_clear = 0; a_up = 0;
        tick();
        vectors++;
        if (a_count !== 4'd9 || a_gray !== 4'b1101) begin
            miscompares++;
            $display("[TB] FAIL prio_set got count=%0d gray=%b want 9 1101", a_count, a_gray);
        end
        a_set = 0; a_up = 1; a_down = 1;
        tick();
        vectors++;
        if (a_count !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL both_hold got %0d want 9", a_count);
        end
        a_up = 0;
        tick();
        vectors++;
        if (a_count !== 4'd8 || a_gray !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL down_step got count=%0d gray=%b want 8 1100", a_count, a_gray);
        end
        a_down = 0;
        a_set = 1; a_set_value = 4'd15;
        tick();
        a_set_value = 4'd0;
        tick();
        vectors++;
        if (a_count !== 4'd0 || a_wrap !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL set_no_wrap got count=%0d wrap=%b want 0 0", a_count, a_wrap);
        end
        a_set = 0;
        // Decrement across 0 must wrap and pulse.
        a_down = 1;
        tick();
        a_down = 0;
        vectors++;
        if (a_count !== 4'd15 || a_wrap !== 1'b1 || a_gray !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL down_wrap got count=%0d wrap=%b gray=%b want 15 1 1000",
                     a_count, a_wrap, a_gray);
        end
    endtask

    task automatic test_set_gray();
        c_set = 1; c_set_value = 8'b1100_0000;
        tick();
        vectors++;
        if (c_count !== 8'd128 || c_gray !== 8'b1100_0000) begin
            miscompares++;
            $display("[TB] FAIL set_gray_c0 got count=%0d gray=%b want 128 11000000", c_count, c_gray);
        end
        c_set_value = 8'b1000_0000;
        tick();
        vectors++;
        if (c_count !== 8'd255 || c_at_max !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL set_gray_80 got count=%0d max=%b want 255 1", c_count, c_at_max);
        end
        c_set_value = 8'b0000_0011;
        tick();
        c_set = 0;
        vectors++;
        if (c_count !== 8'd2 || c_gray !== 8'b0000_0011) begin
            miscompares++;
            $display("[TB] FAIL set_gray_03 got count=%0d gray=%b want 2 00000011", c_count, c_gray);
        end
    endtask

    task automatic test_width_one();
        logic [0:0] exp_cnt  [3] = '{1'b1, 1'b0, 1'b1};
        logic       exp_wrap [3] = '{1'b0, 1'b1, 1'b0};
        d_up = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (d_count !== exp_cnt[i] || d_gray !== exp_cnt[i] || d_wrap !== exp_wrap[i]) begin
                miscompares++;
                $display("[TB] FAIL width1 step %0d got count=%b gray=%b wrap=%b want %b %b %b",
                         i, d_count, d_gray, d_wrap, exp_cnt[i], exp_cnt[i], exp_wrap[i]);
            end
        end
        d_up = 0;
    endtask

    task automatic test_async_reset();
        a_set = 1; a_set_value = 4'd10;
        tick();
        a_set = 0; a_up = 1;
        tick();
        tick();
        vectors++;
        if (a_count !== 4'd12) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_count got %0d want 12", a_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_count !== 4'd5 || a_gray !== 4'b0111 || a_wrap !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got count=%0d gray=%b wrap=%b want 5 0111 0",
                     a_count, a_gray, a_wrap);
        end
        #2;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (a_count !== 4'd6 || a_gray !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL resume_count got count=%0d gray=%b want 6 0101", a_count, a_gray);
        end
        a_up = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        test_reset();
        test_wrap_count();
        test_saturate();
        test_priority();
        test_set_gray();
        test_width_one();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_std_gray_counter

// File: doc/std_gray_counter.md
# std_gray_counter

Parametrised up/down binary counter whose value is also presented as a registered, glitch-free Gray code, for crossing pointers and counters into other clock domains and for low-toggle state encodings. Successor to the purely combinational std_gray_encoder: adds state, direction control, synchronous clear/load (binary or Gray), wrap or saturate mode, and boundary flags. It sits next to FIFO pointer logic and event counters in the std library.

## Interface
- WIDTH, 8, counter width in bits; legal range 1..32
- INITIAL_VALUE, 0, binary reset and clear value; must fit in WIDTH bits
- WRAP, 1, 1 = modulo-2^WIDTH wrap; 0 = saturate at 0 and at 2^WIDTH-1
- SET_GRAY, 0, 1 = i_set_value is Gray-encoded; 0 = i_set_value is binary
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_clear  input  1  synchronous return to INITIAL_VALUE
- i_set  input  1  synchronous load of i_set_value
- i_set_value  input  WIDTH  load value, encoding per SET_GRAY
- i_up  input  1  increment request
- i_down  input  1  decrement request
- o_count  output  WIDTH  registered binary count
- o_gray  output  WIDTH  registered Gray code of o_count
- o_at_max  output  1  o_count == 2^WIDTH-1
- o_at_min  output  1  o_count == 0
- o_wrap  output  1  one-cycle pulse: previous cycle crossed the 0 / 2^WIDTH-1 boundary

## Operation
- Reset (i_rst_n low, any time, including mid-count): o_count = INITIAL_VALUE, o_gray = INITIAL_VALUE ^ (INITIAL_VALUE >> 1), o_wrap = 0; flags follow o_count.
- Per rising edge, priority: i_clear > i_set > count step.
- i_clear: next = INITIAL_VALUE.
- i_set: next = i_set_value, or the Gray-to-binary decode of i_set_value when SET_GRAY = 1.
- Count step: i_up && !i_down -> +1; i_down && !i_up -> -1; both or neither -> hold.
- Arithmetic is modulo 2^WIDTH with no widening; there is no carry-out port.
- WRAP = 1: +1 at 2^WIDTH-1 gives 0; -1 at 0 gives 2^WIDTH-1; o_wrap = 1 in the following cycle only.
- WRAP = 0: +1 at max holds max; -1 at 0 holds 0; o_wrap is constant 0.
- o_wrap is never raised by clear or set, even when they jump across the boundary.
- o_at_max and o_at_min are combinational decodes of the o_count register, with no extra logic depth on the Gray path.
- WIDTH = 1: the count toggles 0/1; o_gray equals o_count.

## Timing
- Latency: one cycle from the sampled inputs to the o_count, o_gray and o_wrap update.
- o_gray is a register loaded with encode(next), not a combinational encode of o_count.
  - It must never glitch.
  - On single steps exactly one o_gray bit changes per edge, including at the wrap.
- o_gray always equals o_count ^ (o_count >> 1) in the same cycle.
- No handshake: the requests are level-sampled every edge, and a held i_up counts every cycle.
- A reset that deasserts mid-operation resumes from INITIAL_VALUE; requests on the first edge after deassertion are honoured.

## Structure
- No shared package is needed; INITIAL_VALUE's Gray value is a localparam.
- Reuse std_gray_encoder (next-binary -> next-Gray) in front of the o_gray register.
- Reuse std_gray_decoder for the i_set_value path, instantiated only under SET_GRAY = 1.
- Single always_ff with async reset for the o_count, o_gray and o_wrap registers; next-state logic in always_comb.

## Test plan
- Reset with WIDTH = 4, INITIAL_VALUE = 5 -> o_count = 5, o_gray = 4'b0111, o_wrap = 0.
- WIDTH = 4, WRAP = 1, i_up held 17 cycles from 0 -> sequence 0..15,0.
  - Each edge changes exactly one o_gray bit.
  - o_wrap high for one cycle after 15 -> 0.
  - o_at_max high only at 15.
- WRAP = 0, i_down held from 2 for 4 cycles -> 1, 0, 0, 0; o_at_min stays high; o_wrap stays 0.
- Same cycle i_clear = 1, i_set = 1 (value 9), i_up = 1 -> next o_count = INITIAL_VALUE.
- Next cycle i_set only -> 9.
- Next cycle i_up = i_down = 1 -> holds 9.
- SET_GRAY = 1, WIDTH = 8, i_set_value = 8'b1100_0000 -> o_count = 8'd128, o_gray = 8'b1100_0000.
- i_rst_n pulsed low between clock edges during counting -> outputs go to reset values immediately (asynchronously).
  - Counting resumes from INITIAL_VALUE on the first edge after release.
